// File: rtl/lc3b_types.sv
// Shared LC-3b types: opcodes, register indices and the hazard unit's shadow state.
package lc3b_types;

    typedef enum logic [3:0] {
        OP_BR    = 4'h0,
        OP_ADD   = 4'h1,
        OP_LDB   = 4'h2,
        OP_STB   = 4'h3,
        OP_JSR   = 4'h4,
        OP_AND   = 4'h5,
        OP_LDW   = 4'h6,
        OP_STW   = 4'h7,
        OP_RTI   = 4'h8,
        OP_XOR   = 4'h9,
        OP_RSV_A = 4'hA,
        OP_RSV_B = 4'hB,
        OP_JMP   = 4'hC,
        OP_SHF   = 4'hD,
        OP_LEA   = 4'hE,
        OP_TRAP  = 4'hF
    } lc3b_opcode;

    typedef logic [2:0] lc3b_reg;

    // IDLE: normal issue. SHADOW: bubbles behind an issued control instruction.
    typedef enum logic {
        IDLE   = 1'b0,
        SHADOW = 1'b1
    } lc3b_hazard_state;

endpackage

// File: rtl/hazard_scoreboard_if.sv
// Bundle between the decode stage (master) and the hazard scoreboard (slave).
//
// Handshake: issue_valid is held by decode until the instruction is accepted;
// an instruction is accepted in a cycle where issue_valid & load_front &
// !insert_nop. Writebacks (wb_valid) are accepted whenever load_back is high.
interface hazard_scoreboard_if
    import lc3b_types::*;
#(
    parameter int NUM_REGS   = 8,
    parameter int NUM_SRC    = 3,
    parameter int PIPE_DEPTH = 4
);
    localparam int IDX_W = $clog2(NUM_REGS);
    localparam int CNT_W = $clog2(PIPE_DEPTH + 1);

    logic                     issue_valid;
    logic                     issue_uses_dest;
    logic [IDX_W-1:0]         issue_dest;
    logic [NUM_SRC-1:0]       src_used;
    logic [NUM_SRC*IDX_W-1:0] src_idx;
    logic                     issue_is_ctrl;
    logic                     wb_valid;
    logic [IDX_W-1:0]         wb_dest;
    logic                     flush;
    logic [CNT_W-1:0]         flush_keep;
    logic                     fetch_miss;
    logic                     mem_miss;
    logic                     ex_stall;

    logic                     load_front;
    logic                     load_ex;
    logic                     load_back;
    logic                     insert_nop;
    logic                     data_hazard;
    logic [NUM_REGS-1:0]      busy_mask;
    logic [CNT_W-1:0]         inflight;
    logic                     wb_mismatch;
    lc3b_hazard_state         shadow_state;

    modport master (
        output issue_valid, issue_uses_dest, issue_dest, src_used, src_idx,
               issue_is_ctrl, wb_valid, wb_dest, flush, flush_keep,
               fetch_miss, mem_miss, ex_stall,
        input  load_front, load_ex, load_back, insert_nop, data_hazard,
               busy_mask, inflight, wb_mismatch, shadow_state
    );

    modport slave (
        input  issue_valid, issue_uses_dest, issue_dest, src_used, src_idx,
               issue_is_ctrl, wb_valid, wb_dest, flush, flush_keep,
               fetch_miss, mem_miss, ex_stall,
        output load_front, load_ex, load_back, insert_nop, data_hazard,
               busy_mask, inflight, wb_mismatch, shadow_state
    );

endinterface

// File: rtl/inflight_queue.sv
// Circular FIFO of in-flight destination registers, oldest at head.
// Supports push, pop (applied first) and truncation to the oldest 'keep' entries.
module inflight_queue #(
    parameter  int DEPTH = 4,
    parameter  int IDX_W = 3,
    localparam int CNT_W = $clog2(DEPTH + 1),
    localparam int PTR_W = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [IDX_W-1:0] push_dest,
    input  logic             pop,
    input  logic             truncate,
    input  logic [CNT_W-1:0] keep,
    output logic [IDX_W-1:0] head_dest,
    output logic [CNT_W-1:0] count,
    output logic             full,
    output logic             empty,
    output logic [DEPTH-1:0] ent_valid,
    output logic [IDX_W-1:0] ent_dest [DEPTH]
);
    logic [IDX_W-1:0] mem [DEPTH];
    logic [PTR_W-1:0] head_q;
    logic [PTR_W-1:0] tail;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_after_pop;
    logic             pop_ok;
    logic             push_ok;

    function automatic logic [PTR_W-1:0] wrap_add(input logic [PTR_W-1:0] p,
                                                  input logic [CNT_W-1:0] n);
        int sum;
        sum = int'(p) + int'(n);
        if (sum >= DEPTH) sum = sum - DEPTH;
        return PTR_W'(sum);
    endfunction

    assign empty         = (cnt_q == '0);
    assign full          = (cnt_q == CNT_W'(DEPTH));
    assign pop_ok        = pop & !empty;
    // A full queue only takes a push when the head leaves in the same cycle.
    assign push_ok       = push & !truncate & (!full | pop_ok);
    assign tail          = wrap_add(head_q, cnt_q);
    assign head_dest     = mem[head_q];
    assign count         = cnt_q;
    assign cnt_after_pop = cnt_q - CNT_W'(pop_ok);

    // Head pointer and occupancy; truncation sees the post-pop occupancy.
    always_ff @(posedge clk) begin
        if (rst) begin
            head_q <= '0;
            cnt_q  <= '0;
        end else begin
            if (pop_ok) head_q <= wrap_add(head_q, CNT_W'(1));
            if (truncate) cnt_q <= (keep < cnt_after_pop) ? keep : cnt_after_pop;
            else          cnt_q <= cnt_after_pop + CNT_W'(push_ok);
        end
    end

    // Entry storage; contents are only meaningful while the entry is valid.
    always_ff @(posedge clk) begin
        if (push_ok) mem[tail] <= push_dest;
    end

    // Per-entry export: an entry is valid if it lies within count of head.
    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            if (PTR_W'(i) >= head_q)
                ent_valid[i] = (i - int'(head_q)) < int'(cnt_q);
            else
                ent_valid[i] = (i + DEPTH - int'(head_q)) < int'(cnt_q);
            ent_dest[i] = mem[i];
        end
    end

endmodule

// File: rtl/hazard_scoreboard.sv
// Issue-stage hazard unit: in-order write queue, control-flow shadow,
// deferred flush, and per-stage load enables / bubble insertion.
module hazard_scoreboard
    import lc3b_types::*;
#(
    parameter int NUM_REGS   = 8,
    parameter int NUM_SRC    = 3,
    parameter int PIPE_DEPTH = 4,
    parameter int BR_SHADOW  = 3
) (
    input logic               clk,
    input logic               rst,
    hazard_scoreboard_if.slave bus
);
    localparam int IDX_W = $clog2(NUM_REGS);
    localparam int CNT_W = $clog2(PIPE_DEPTH + 1);
    localparam int SH_W  = (BR_SHADOW < 2) ? 1 : $clog2(BR_SHADOW + 1);

    logic [IDX_W-1:0]      head_dest;
    logic [CNT_W-1:0]      q_count;
    logic                  q_full;
    logic                  q_empty;
    logic [PIPE_DEPTH-1:0] ent_valid;
    logic [IDX_W-1:0]      ent_dest [PIPE_DEPTH];

    logic [NUM_REGS-1:0]   busy;
    logic                  hazard;
    logic                  pop_req;
    logic                  push_req;
    logic                  accept;
    logic                  nop;
    logic                  ld_back;
    logic                  ld_ex;
    logic                  ld_front;
    lc3b_hazard_state      state;
    logic [SH_W-1:0]       sh_cnt;
    logic                  flush_pend;
    logic                  mismatch;

    inflight_queue #(.DEPTH(PIPE_DEPTH), .IDX_W(IDX_W)) u_queue (
        .clk       (clk),
        .rst       (rst),
        .push      (push_req),
        .push_dest (bus.issue_dest),
        .pop       (pop_req),
        .truncate  (bus.flush),
        .keep      (bus.flush_keep),
        .head_dest (head_dest),
        .count     (q_count),
        .full      (q_full),
        .empty     (q_empty),
        .ent_valid (ent_valid),
        .ent_dest  (ent_dest)
    );

    // A register is busy while any queued write targets it.
    always_comb begin
        busy = '0;
        for (int e = 0; e < PIPE_DEPTH; e++)
            if (ent_valid[e]) busy[ent_dest[e]] = 1'b1;
    end

    // Any used source that reads a busy register stalls issue (no bypass).
    always_comb begin
        hazard = 1'b0;
        for (int s = 0; s < NUM_SRC; s++)
            if (bus.src_used[s] && busy[bus.src_idx[s*IDX_W +: IDX_W]]) hazard = 1'b1;
    end

    assign ld_back  = !bus.mem_miss & !(bus.fetch_miss & bus.flush);
    assign ld_ex    = ld_back & !bus.ex_stall;
    assign pop_req  = bus.wb_valid & ld_back;
    assign nop      = hazard | bus.fetch_miss | (state == SHADOW) | bus.flush
                    | flush_pend | (q_full & !pop_req);
    assign ld_front = ld_ex & (!nop | bus.flush | (flush_pend & !bus.fetch_miss));
    assign accept   = bus.issue_valid & ld_front & !nop;
    assign push_req = accept & bus.issue_uses_dest;

    assign bus.load_back    = ld_back;
    assign bus.load_ex      = ld_ex;
    assign bus.load_front   = ld_front;
    assign bus.insert_nop   = nop;
    assign bus.data_hazard  = hazard;
    assign bus.busy_mask    = busy;
    assign bus.inflight     = q_count;
    assign bus.wb_mismatch  = mismatch;
    assign bus.shadow_state = state;

    // Control-flow shadow: BR_SHADOW bubbles, frozen while mem_miss holds the pipe.
    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            sh_cnt <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept && bus.issue_is_ctrl && BR_SHADOW > 0) begin
                        state  <= SHADOW;
                        sh_cnt <= SH_W'(BR_SHADOW - 1);
                    end
                end
                SHADOW: begin
                    if (bus.flush) begin
                        state <= IDLE;
                    end else if (!bus.mem_miss) begin
                        if (sh_cnt == '0) state <= IDLE;
                        else              sh_cnt <= sh_cnt - SH_W'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Deferred flush across an I-cache miss, and the sticky writeback-order error.
    always_ff @(posedge clk) begin
        if (rst) begin
            flush_pend <= 1'b0;
            mismatch   <= 1'b0;
        end else begin
            if (bus.flush && bus.fetch_miss) flush_pend <= 1'b1;
            else if (!bus.fetch_miss)        flush_pend <= 1'b0;
            if (pop_req && (q_empty || bus.wb_dest != head_dest)) mismatch <= 1'b1;
        end
    end

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Directed bench for hazard_scoreboard (NUM_REGS=8, NUM_SRC=3, PIPE_DEPTH=4, BR_SHADOW=3).
module tb_hazard_scoreboard;
    import lc3b_types::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_vec = 0;
    int   n_err = 0;
    int   nop_cnt;
    logic [2:0] exp_q[$];

    always #5 clk = ~clk;

    hazard_scoreboard_if #(.NUM_REGS(8), .NUM_SRC(3), .PIPE_DEPTH(4)) bus ();

    hazard_scoreboard #(.NUM_REGS(8), .NUM_SRC(3), .PIPE_DEPTH(4), .BR_SHADOW(3)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] exp_busy();
        logic [7:0] m;
        m = '0;
        foreach (exp_q[i]) m[exp_q[i]] = 1'b1;
        return m;
    endfunction

    task automatic check_queue(input string tag);
        check({tag, "_inflight"}, 32'(bus.inflight), 32'(exp_q.size()));
        check({tag, "_busy"}, 32'(bus.busy_mask), 32'(exp_busy()));
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic clear_in();
        bus.issue_valid     = 1'b0;
        bus.issue_uses_dest = 1'b0;
        bus.issue_dest      = '0;
        bus.src_used        = '0;
        bus.src_idx         = '0;
        bus.issue_is_ctrl   = 1'b0;
        bus.wb_valid        = 1'b0;
        bus.wb_dest         = '0;
        bus.flush           = 1'b0;
        bus.flush_keep      = '0;
        bus.fetch_miss      = 1'b0;
        bus.mem_miss        = 1'b0;
        bus.ex_stall        = 1'b0;
    endtask

    task automatic set_issue(input logic [2:0] dest, input logic uses, input logic [2:0] used,
                             input logic [8:0] idx, input logic ctrl);
        bus.issue_valid     = 1'b1;
        bus.issue_uses_dest = uses;
        bus.issue_dest      = dest;
        bus.src_used        = used;
        bus.src_idx         = idx;
        bus.issue_is_ctrl   = ctrl;
    endtask

    task automatic end_issue();
        bus.issue_valid   = 1'b0;
        bus.issue_is_ctrl = 1'b0;
        bus.src_used      = '0;
    endtask

    task automatic push_one(input logic [2:0] dest);
        set_issue(dest, 1'b1, 3'b000, 9'd0, 1'b0);
        tick();
        exp_q.push_back(dest);
        end_issue();
    endtask

    task automatic pop_one(input logic [2:0] dest);
        bus.wb_valid = 1'b1;
        bus.wb_dest  = dest;
        tick();
        void'(exp_q.pop_front());
        bus.wb_valid = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        clear_in();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        settle();

        // Reset state.
        check_queue("rst");
        check("rst_hazard", 32'(bus.data_hazard), 0);
        check("rst_nop", 32'(bus.insert_nop), 0);
        check("rst_load_front", 32'(bus.load_front), 1);
        check("rst_load_ex", 32'(bus.load_ex), 1);
        check("rst_load_back", 32'(bus.load_back), 1);
        check("rst_mismatch", 32'(bus.wb_mismatch), 0);
        check("rst_state", 32'(bus.shadow_state), 32'(IDLE));

        // RAW: ADD R1, then ADD R2 <- R1 waits for R1's writeback.
        push_one(3'd1);
        settle();
        check_queue("t1_push");
        set_issue(3'd2, 1'b1, 3'b001, 9'd1, 1'b0);
        settle();
        check("t1_hazard", 32'(bus.data_hazard), 1);
        check("t1_nop", 32'(bus.insert_nop), 1);
        check("t1_load_front", 32'(bus.load_front), 0);
        tick();
        check("t1_hold_hazard", 32'(bus.data_hazard), 1);
        check_queue("t1_hold");
        bus.wb_valid = 1'b1;
        bus.wb_dest  = 3'd1;
        settle();
        check("t1_nobypass_hazard", 32'(bus.data_hazard), 1);
        check("t1_nobypass_nop", 32'(bus.insert_nop), 1);
        tick();
        void'(exp_q.pop_front());
        bus.wb_valid = 1'b0;
        settle();
        check("t1_free_hazard", 32'(bus.data_hazard), 0);
        check("t1_free_nop", 32'(bus.insert_nop), 0);
        check("t1_free_load_front", 32'(bus.load_front), 1);
        tick();
        exp_q.push_back(3'd2);
        end_issue();
        settle();
        check_queue("t1_r2");
        pop_one(3'd2);
        settle();
        check_queue("t1_drain");

        // Two outstanding writes to R3.
        push_one(3'd3);
        push_one(3'd3);
        settle();
        check_queue("t2_two");
        pop_one(3'd3);
        settle();
        check("t2_r3_still_busy", 32'(bus.busy_mask[3]), 1);
        check_queue("t2_one");
        pop_one(3'd3);
        settle();
        check_queue("t2_none");

        // Full queue: fifth writer stalls without wb, goes with wb.
        push_one(3'd4);
        push_one(3'd5);
        push_one(3'd6);
        push_one(3'd7);
        settle();
        check_queue("t3_full");
        set_issue(3'd1, 1'b1, 3'b000, 9'd0, 1'b0);
        settle();
        check("t3_full_nop", 32'(bus.insert_nop), 1);
        check("t3_full_load_front", 32'(bus.load_front), 0);
        tick();
        check_queue("t3_blocked");
        bus.wb_valid = 1'b1;
        bus.wb_dest  = 3'd4;
        settle();
        check("t3_pushpop_nop", 32'(bus.insert_nop), 0);
        tick();
        void'(exp_q.pop_front());
        exp_q.push_back(3'd1);
        end_issue();
        bus.wb_valid = 1'b0;
        settle();
        check_queue("t3_pushpop");
        check("t3_busy_const", 32'(bus.busy_mask), 32'h0000_00e2);
        pop_one(3'd5);
        pop_one(3'd6);
        pop_one(3'd7);
        pop_one(3'd1);
        settle();
        check_queue("t3_drain");
        check("t3_mismatch", 32'(bus.wb_mismatch), 0);

        // Branch shadow with mem_miss high for two cycles mid-shadow.
        set_issue(3'd0, 1'b0, 3'b000, 9'd0, 1'b1);
        settle();
        check("t4_br_nop", 32'(bus.insert_nop), 0);
        tick();
        end_issue();
        nop_cnt = 0;
        for (int k = 0; k < 20; k++) begin
            bus.mem_miss = (k == 1 || k == 2);
            settle();
            if (k == 0) check("t4_state_shadow", 32'(bus.shadow_state), 32'(SHADOW));
            if (!bus.insert_nop) break;
            nop_cnt++;
            tick();
        end
        bus.mem_miss = 1'b0;
        settle();
        check("t4_nop_cycles", 32'(nop_cnt), 5);
        check("t4_state_idle", 32'(bus.shadow_state), 32'(IDLE));
        check_queue("t4_queue");

        // Flush keep=1 during a two-cycle fetch miss.
        push_one(3'd1);
        push_one(3'd2);
        push_one(3'd3);
        settle();
        check_queue("t5_three");
        bus.flush      = 1'b1;
        bus.flush_keep = 3'd1;
        bus.fetch_miss = 1'b1;
        settle();
        check("t5_flush_load_front", 32'(bus.load_front), 0);
        check("t5_flush_load_back", 32'(bus.load_back), 0);
        check("t5_flush_nop", 32'(bus.insert_nop), 1);
        tick();
        while (exp_q.size() > 1) void'(exp_q.pop_back());
        bus.flush      = 1'b0;
        bus.flush_keep = '0;
        settle();
        check_queue("t5_trunc");
        check("t5_miss_load_front", 32'(bus.load_front), 0);
        tick();
        bus.fetch_miss = 1'b0;
        settle();
        check("t5_pend_load_front", 32'(bus.load_front), 1);
        check("t5_pend_nop", 32'(bus.insert_nop), 1);
        tick();
        check("t5_after_nop", 32'(bus.insert_nop), 0);
        check("t5_after_load_front", 32'(bus.load_front), 1);
        pop_one(3'd1);
        settle();
        check_queue("t5_drain");

        // Flush keep=2 with a pop in the same cycle: pop first, then truncate.
        push_one(3'd1);
        push_one(3'd2);
        push_one(3'd3);
        bus.flush      = 1'b1;
        bus.flush_keep = 3'd2;
        bus.wb_valid   = 1'b1;
        bus.wb_dest    = 3'd1;
        settle();
        check("t5b_load_back", 32'(bus.load_back), 1);
        tick();
        void'(exp_q.pop_front());
        while (exp_q.size() > 2) void'(exp_q.pop_back());
        bus.flush      = 1'b0;
        bus.flush_keep = '0;
        bus.wb_valid   = 1'b0;
        settle();
        check_queue("t5b_trunc");
        pop_one(3'd2);
        pop_one(3'd3);
        settle();
        check_queue("t5b_drain");
        check("t5b_mismatch", 32'(bus.wb_mismatch), 0);

        // Writeback order error is sticky; reset clears it along with queue and shadow.
        push_one(3'd2);
        bus.wb_valid = 1'b1;
        bus.wb_dest  = 3'd5;
        tick();
        void'(exp_q.pop_front());
        bus.wb_valid = 1'b0;
        settle();
        check("t6_mismatch_set", 32'(bus.wb_mismatch), 1);
        check_queue("t6_popped");
        tick();
        tick();
        check("t6_mismatch_sticky", 32'(bus.wb_mismatch), 1);
        push_one(3'd6);
        set_issue(3'd0, 1'b0, 3'b000, 9'd0, 1'b1);
        tick();
        end_issue();
        settle();
        check("t6_pre_rst_state", 32'(bus.shadow_state), 32'(SHADOW));
        check_queue("t6_pre_rst");
        rst = 1'b1;
        tick();
        rst = 1'b0;
        exp_q.delete();
        settle();
        check_queue("t6_rst");
        check("t6_rst_state", 32'(bus.shadow_state), 32'(IDLE));
        check("t6_rst_mismatch", 32'(bus.wb_mismatch), 0);
        check("t6_rst_nop", 32'(bus.insert_nop), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
